// File: rtl/rpc_io_dir_ctrl.sv
// RPC DRAM pad direction sequencer: drives DQS/DB output, input and
// pull-down enables around write bursts and read windows.
module rpc_io_dir_ctrl #(
    parameter int unsigned TURN_CYC = 2,
    parameter int unsigned PRE_CYC  = 1,
    parameter int unsigned POST_CYC = 1,
    parameter int unsigned RD_TO    = 64,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [CNT_W-1:0] req_len_i,
    input  logic             rd_last_i,
    output logic             oe_dqs_o,
    output logic             oe_db_o,
    output logic             ie_dqs_o,
    output logic             ie_db_o,
    output logic             pd_en_dqs_o,
    output logic             pd_en_db_o,
    output logic             dqs_en_o,
    output logic             beat_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic             busy_o
);

    localparam int unsigned TO_W = $clog2(RD_TO + 1);
    localparam int unsigned TU_W = $clog2(TURN_CYC + 1);
    localparam int unsigned PR_W = $clog2(PRE_CYC + 1);
    localparam int unsigned PO_W = $clog2(POST_CYC + 1);
    localparam int unsigned W1   = (CNT_W > TO_W) ? CNT_W : TO_W;
    localparam int unsigned W2   = (W1 > TU_W) ? W1 : TU_W;
    localparam int unsigned W3   = (W2 > PR_W) ? W2 : PR_W;
    localparam int unsigned CW   = (W3 > PO_W) ? W3 : PO_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_W_PRE,
        S_W_DATA,
        S_W_POST,
        S_R_WIN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             op_wr_q, op_wr_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             ld_vld_q, ld_vld_d;
    logic             ld_wr_q, ld_wr_d;

    logic             cnt_zero;
    logic             accept;
    logic             first_wr;
    logic [CNT_W-1:0] first_len;
    state_e           first_st;
    logic [CW-1:0]    first_cnt;

    assign cnt_zero = (cnt_q == '0);
    assign accept   = req_valid_i && (state_q == S_IDLE);

    // Entry point of the op body, from IDLE directly or after TURN
    always_comb begin
        first_wr  = (state_q == S_IDLE) ? req_write_i : op_wr_q;
        first_len = (state_q == S_IDLE) ? req_len_i : len_q;
        first_st  = S_R_WIN;
        first_cnt = CW'(RD_TO - 1);
        if (first_wr) begin
            if (PRE_CYC != 0) begin
                first_st  = S_W_PRE;
                first_cnt = CW'(PRE_CYC - 1);
            end else begin
                first_st  = S_W_DATA;
                first_cnt = CW'(first_len);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_wr_d  = op_wr_q;
        len_d    = len_q;
        ld_vld_d = ld_vld_q;
        ld_wr_d  = ld_wr_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_wr_d  = req_write_i;
                    len_d    = req_len_i;
                    ld_vld_d = 1'b1;
                    ld_wr_d  = req_write_i;
                    if (ld_vld_q && (ld_wr_q != req_write_i)
                        && (TURN_CYC != 0)) begin
                        state_d = S_TURN;
                        cnt_d   = CW'(TURN_CYC - 1);
                    end else begin
                        state_d = first_st;
                        cnt_d   = first_cnt;
                    end
                end
            end
            S_TURN: begin
                if (cnt_zero) begin
                    state_d = first_st;
                    cnt_d   = first_cnt;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_W_PRE: begin
                if (cnt_zero) begin
                    state_d = S_W_DATA;
                    cnt_d   = CW'(len_q);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_W_DATA: begin
                if (cnt_zero) begin
                    if (POST_CYC != 0) begin
                        state_d = S_W_POST;
                        cnt_d   = CW'(POST_CYC - 1);
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_W_POST: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_R_WIN: begin
                if (rd_last_i || cnt_zero) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_wr_q  <= 1'b0;
            len_q    <= '0;
            ld_vld_q <= 1'b0;
            ld_wr_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_wr_q  <= op_wr_d;
            len_q    <= len_d;
            ld_vld_q <= ld_vld_d;
            ld_wr_q  <= ld_wr_d;
        end
    end

    // rd_last_i only reaches done/timeout while the read window is open
    always_comb begin
        oe_dqs_o    = 1'b0;
        oe_db_o     = 1'b0;
        ie_dqs_o    = 1'b0;
        ie_db_o     = 1'b0;
        pd_en_dqs_o = 1'b1;
        pd_en_db_o  = 1'b1;
        dqs_en_o    = 1'b0;
        beat_o      = 1'b0;
        done_o      = 1'b0;
        timeout_o   = 1'b0;
        unique case (state_q)
            S_W_PRE: begin
                oe_dqs_o    = 1'b1;
                oe_db_o     = 1'b1;
                pd_en_dqs_o = 1'b0;
                pd_en_db_o  = 1'b0;
            end
            S_W_DATA: begin
                oe_dqs_o    = 1'b1;
                oe_db_o     = 1'b1;
                pd_en_dqs_o = 1'b0;
                pd_en_db_o  = 1'b0;
                dqs_en_o    = 1'b1;
                beat_o      = 1'b1;
                done_o      = cnt_zero && (POST_CYC == 0);
            end
            S_W_POST: begin
                oe_dqs_o    = 1'b1;
                pd_en_dqs_o = 1'b0;
                done_o      = cnt_zero;
            end
            S_R_WIN: begin
                ie_dqs_o    = 1'b1;
                ie_db_o     = 1'b1;
                pd_en_dqs_o = 1'b0;
                pd_en_db_o  = 1'b0;
                done_o      = rd_last_i || cnt_zero;
                timeout_o   = cnt_zero && !rd_last_i;
            end
            default: begin
            end
        endcase
    end

    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rpc_io_dir_ctrl.sv
// Randomized bench for rpc_io_dir_ctrl; expected per-cycle output
// traces are built from op rules and played against the DUT.
module tb_rpc_io_dir_ctrl;

    localparam int TURN_CYC = 2;
    localparam int PRE_CYC  = 1;
    localparam int POST_CYC = 1;
    localparam int RD_TO    = 64;
    localparam int CNT_W    = 8;

    // {ready,busy,oe_dqs,oe_db,ie_dqs,ie_db,pd_dqs,pd_db,dqs_en,beat,done,to}
    localparam logic [11:0] V_IDLE = 12'b1_0_00_00_11_00_00;
    localparam logic [11:0] V_TURN = 12'b0_1_00_00_11_00_00;
    localparam logic [11:0] V_PRE  = 12'b0_1_11_00_00_00_00;
    localparam logic [11:0] V_DATA = 12'b0_1_11_00_00_11_00;
    localparam logic [11:0] V_POST = 12'b0_1_10_00_01_00_00;
    localparam logic [11:0] V_RWIN = 12'b0_1_00_11_00_00_00;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_write = 1'b0;
    logic [CNT_W-1:0] req_len = '0;
    logic             rd_last = 1'b0;
    logic oe_dqs, oe_db, ie_dqs, ie_db, pd_dqs, pd_db;
    logic dqs_en, beat, done, timeout, busy;
    logic [11:0] obs;

    int checks = 0;
    int errors = 0;
    int opn = 0;
    bit ld_known = 1'b0;
    bit ld_wr = 1'b0;

    always #5 clk = ~clk;

    rpc_io_dir_ctrl #(
        .TURN_CYC(TURN_CYC), .PRE_CYC(PRE_CYC), .POST_CYC(POST_CYC),
        .RD_TO(RD_TO), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_len_i(req_len),
        .rd_last_i(rd_last),
        .oe_dqs_o(oe_dqs), .oe_db_o(oe_db),
        .ie_dqs_o(ie_dqs), .ie_db_o(ie_db),
        .pd_en_dqs_o(pd_dqs), .pd_en_db_o(pd_db),
        .dqs_en_o(dqs_en), .beat_o(beat),
        .done_o(done), .timeout_o(timeout), .busy_o(busy)
    );

    assign obs = {req_ready, busy, oe_dqs, oe_db, ie_dqs, ie_db,
                  pd_dqs, pd_db, dqs_en, beat, done, timeout};

    task automatic check_eq(input string tag, input logic [11:0] got,
                            input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        req_valid = 1'b0;
        rd_last   = 1'($urandom);
        #1;
        check_eq($sformatf("gap op%0d", opn), obs, V_IDLE);
    endtask

    // k = R_WIN cycle (1-based) carrying rd_last; k > RD_TO never sends it
    task automatic play_op(input bit wr, input int len, input int k,
                           input int abort_at);
        logic [11:0] eq[$];
        logic        rq[$];
        logic [11:0] v;
        int          n;
        bit          turn;
        turn = ld_known && (ld_wr != wr) && (TURN_CYC > 0);
        eq.push_back(V_IDLE);
        rq.push_back(1'($urandom));
        if (turn) begin
            repeat (TURN_CYC) begin
                eq.push_back(V_TURN);
                rq.push_back(1'($urandom));
            end
        end
        if (wr) begin
            repeat (PRE_CYC) begin
                eq.push_back(V_PRE);
                rq.push_back(1'($urandom));
            end
            repeat (len + 1) begin
                eq.push_back(V_DATA);
                rq.push_back(1'($urandom));
            end
            repeat (POST_CYC) begin
                eq.push_back(V_POST);
                rq.push_back(1'($urandom));
            end
        end else begin
            n = (k < RD_TO) ? k : RD_TO;
            for (int j = 1; j <= n; j++) begin
                eq.push_back(V_RWIN);
                rq.push_back(j == k);
            end
        end
        v = eq.pop_back();
        v[1] = 1'b1;
        v[0] = !wr && (k > RD_TO);
        eq.push_back(v);
        ld_known = 1'b1;
        ld_wr    = wr;
        opn++;
        foreach (eq[i]) begin
            @(negedge clk);
            if (i == 0) begin
                req_valid = 1'b1;
                req_write = wr;
                req_len   = CNT_W'(len);
            end else begin
                req_valid = 1'($urandom);
                req_write = 1'($urandom);
                req_len   = CNT_W'($urandom);
            end
            rd_last = rq[i];
            #1;
            check_eq($sformatf("op%0d wr%0d c%0d", opn, wr, i), obs, eq[i]);
            if (i == abort_at) begin
                rst_ni = 1'b0;
                #1;
                check_eq("async_rst", obs, V_IDLE);
                ld_known = 1'b0;
                @(negedge clk);
                req_valid = 1'b0;
                rd_last   = 1'b0;
                #1;
                check_eq("rst_held", obs, V_IDLE);
                rst_ni = 1'b1;
                return;
            end
        end
    endtask

    initial begin
        repeat (2) begin
            @(negedge clk);
            req_valid = 1'($urandom);
            rd_last   = 1'($urandom);
            #1;
            check_eq("reset", obs, V_IDLE);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rst_ni    = 1'b1;
        #1;
        check_eq("post_reset", obs, V_IDLE);

        play_op(1'b1, 3, 0, -1);
        play_op(1'b0, 0, 5, -1);
        idle_cycle();
        play_op(1'b0, 0, 1000, -1);
        play_op(1'b0, 0, RD_TO, -1);
        play_op(1'b1, 0, 0, -1);
        play_op(1'b1, 0, 0, -1);
        play_op(1'b1, 7, 0, 3);
        play_op(1'b0, 0, 3, -1);
        play_op(1'b0, 0, 1, -1);
        play_op(1'b1, 255, 0, -1);

        for (int r = 0; r < 60; r++) begin
            int kk;
            kk = ($urandom_range(0, 5) == 0) ? RD_TO + 1 + $urandom_range(0, 9)
                                             : $urandom_range(1, RD_TO);
            repeat ($urandom_range(0, 2)) idle_cycle();
            play_op(1'($urandom), $urandom_range(0, 12), kk,
                    ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
